// File: rtl/uart_sample_loader_pkg.sv
// uart_sample_loader_pkg
// Shared constants and state encodings for the UART sample loader slice.
//   - Baud divisor constant for a 12 MHz system clock.
//   - Default sample word width, buffer address width and inter-byte timeout.
//   - State encodings for the loader FSM and the 8N1 byte receiver.
package uart_sample_loader_pkg;

  // Clock cycles per UART bit at 115200 baud with a 12 MHz clock.
  localparam int B115200_12MHZ = 104;

  localparam int DEFAULT_DW      = 16;
  localparam int DEFAULT_AW      = 12;
  localparam int DEFAULT_TIMEOUT = 2048;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_WAIT_HI,
    LD_WAIT_LO,
    LD_FULL
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
// Two-flop synchronizer plus 8N1 deserializer for one UART byte at a time.
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high (also aborts a byte in flight)
//   rx         asynchronous serial input, idles high
//   data       received byte, valid while byte_valid is high
//   byte_valid one-cycle pulse: byte received with a good stop bit
//   byte_err   one-cycle pulse: stop bit was low, byte discarded
module uart_rx_byte
  import uart_sample_loader_pkg::*;
#(
  parameter int BAUD = B115200_12MHZ
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int CW = $clog2(BAUD) + 1;
  localparam logic [CW-1:0] HALF_RELOAD = CW'(BAUD / 2 - 1);
  localparam logic [CW-1:0] FULL_RELOAD = CW'(BAUD - 1);

  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  rx_state_t     state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;

  assign data = shift_reg;

  // Synchronizer flops reset to the idle-high line level so that leaving
  // reset never looks like a start-bit falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Counters run down to zero; a sample is taken on the zero cycle.  The
  // start bit is re-checked half a bit in, which also places every later
  // sample near the middle of its bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RX_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state    <= RX_START;
            baud_cnt <= HALF_RELOAD;
          end
        end
        RX_START: begin
          if (baud_cnt == '0) begin
            if (rx_sync) begin
              state <= RX_IDLE;
            end else begin
              state    <= RX_DATA;
              baud_cnt <= FULL_RELOAD;
              bit_cnt  <= '0;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        RX_DATA: begin
          if (baud_cnt == '0) begin
            shift_reg <= {rx_sync, shift_reg[7:1]};
            baud_cnt  <= FULL_RELOAD;
            if (bit_cnt == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        RX_STOP: begin
          if (baud_cnt == '0) begin
            byte_valid <= rx_sync;
            byte_err   <= !rx_sync;
            state      <= RX_IDLE;
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_sample_loader.sv
// uart_sample_loader
// Fills an on-chip buffer with signed 16-bit samples received over UART,
// high byte first, and exposes the buffer through a registered read port.
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   rx         UART serial input, idles high
//   arm        one-cycle pulse: start or restart a buffer load
//   rd_addr    buffer read address
//   rd_data    buffer read data, one cycle after rd_addr
//   busy       load in progress
//   done       buffer full, held until next arm or rst
//   word_count words written in the current load (saturates at 2**AW)
//   frame_err  sticky: a bad stop bit was seen during the load
//   sync_err   sticky: a word was dropped (timeout or frame error mid-word)
module uart_sample_loader
  import uart_sample_loader_pkg::*;
#(
  parameter int BAUD    = B115200_12MHZ,
  parameter int DW      = DEFAULT_DW,
  parameter int AW      = DEFAULT_AW,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  input  logic          arm,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   word_count,
  output logic          frame_err,
  output logic          sync_err
);

  localparam int NPOS = 2 ** AW;
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(NPOS - 1);
  localparam logic [AW:0]   NPOS_COUNT = (AW + 1)'(NPOS);
  localparam logic [TW-1:0] TO_RELOAD  = TW'(TIMEOUT);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_err;
  loader_state_t state;
  logic [7:0]    hi_byte;
  logic [TW-1:0] to_cnt;
  logic          mem_we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] mem [NPOS];

  uart_rx_byte #(
    .BAUD(BAUD)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (rx_data),
    .byte_valid(rx_valid),
    .byte_err  (rx_err)
  );

  // The write strobe is decoded combinationally so the low byte lands in
  // RAM on the same edge the FSM advances.  A byte coinciding with arm is
  // dropped, matching the restart taking priority in the FSM.
  assign wr_addr = word_count[AW-1:0];
  assign wr_data = {hi_byte, rx_data};
  assign mem_we  = !rst && !arm && (state == LD_WAIT_LO) && rx_valid;

  // Simple dual-port RAM: one write port, one registered read port.  The
  // read uses the pre-edge contents, so a same-address write returns old data.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

  // Loader FSM.  arm restarts from any state and discards a pending high
  // byte.  A timeout or bad stop bit between the two bytes of a word drops
  // the half-word so the next byte is taken as a fresh high byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LD_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
      sync_err   <= 1'b0;
      word_count <= '0;
      hi_byte    <= '0;
      to_cnt     <= '0;
    end else if (arm) begin
      state      <= LD_WAIT_HI;
      busy       <= 1'b1;
      done       <= 1'b0;
      frame_err  <= 1'b0;
      sync_err   <= 1'b0;
      word_count <= '0;
    end else begin
      unique case (state)
        LD_IDLE, LD_FULL: begin
        end
        LD_WAIT_HI: begin
          if (rx_valid) begin
            hi_byte <= rx_data;
            to_cnt  <= TO_RELOAD;
            state   <= LD_WAIT_LO;
          end else if (rx_err) begin
            frame_err <= 1'b1;
          end
        end
        LD_WAIT_LO: begin
          if (rx_valid) begin
            if (word_count != NPOS_COUNT) begin
              word_count <= word_count + (AW + 1)'(1);
            end
            if (wr_addr == LAST_ADDR) begin
              state <= LD_FULL;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= LD_WAIT_HI;
            end
          end else if (rx_err) begin
            frame_err <= 1'b1;
            sync_err  <= 1'b1;
            state     <= LD_WAIT_HI;
          end else if (to_cnt == '0) begin
            sync_err <= 1'b1;
            state    <= LD_WAIT_HI;
          end else begin
            to_cnt <= to_cnt - TW'(1);
          end
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule
